// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states,
// ALU operations and datapath select values.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_JMP   = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b0110;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JUMP,
    S_HALT
  } ctrl_state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_SHL = 3'b011;
  localparam logic [2:0] ALU_SHR = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_ONE   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [1:0] {
    ALU_CLS_ADD,
    ALU_CLS_SUB,
    ALU_CLS_FUNCT
  } alu_class_t;

endpackage

// File: rtl/alu_dec.sv
// ALU operation decoder: fixed ADD/SUB per state class, or the R-type funct field.
module alu_dec
  import cpu_ctrl_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [2:0]  funct,
  output logic [2:0]  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_class)
      ALU_CLS_SUB:   alu_control = ALU_SUB;
      ALU_CLS_FUNCT: alu_control = funct;
      default:       alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the 16-bit RISC core; Moore outputs with
// mem_ready/zero qualification in FETCH and BEQ.
module mc_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] op,
  input  logic [2:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] result_src,
  output logic       halted,
  output logic       illegal_op
);

  ctrl_state_t state, next_state;
  alu_class_t  alu_class;

  logic pc_write_s, ir_write_s, mem_write_s, reg_write_s, halted_s, illegal_s;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next_state;
  end

  always_comb begin
    next_state  = state;
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    halted_s    = 1'b0;
    illegal_s   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_class   = ALU_CLS_ADD;

    case (state)
      S_FETCH: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_ONE;
        result_src = RES_ALU;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_RTYPE:     next_state = S_EXECR;
          OP_ADDI:      next_state = S_EXECI;
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_BEQ:       next_state = S_BEQ;
          OP_JMP:       next_state = S_JUMP;
          OP_HALT:      next_state = S_HALT;
          default: begin
            next_state = S_FETCH;
            illegal_s  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_REGA;
        alu_src_b  = SRCB_IMM;
        next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_MEM;
        reg_write_s = 1'b1;
        next_state  = S_FETCH;
      end
      S_MEMWR: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_REGA;
        alu_src_b  = SRCB_REGB;
        alu_class  = ALU_CLS_FUNCT;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_REGA;
        alu_src_b  = SRCB_IMM;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        result_src  = RES_ALUOUT;
        reg_write_s = 1'b1;
        next_state  = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_REGA;
        alu_src_b  = SRCB_REGB;
        alu_class  = ALU_CLS_SUB;
        result_src = RES_ALUOUT;
        pc_write_s = zero;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        result_src = RES_ALUOUT;
        pc_write_s = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT: begin
        halted_s = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  alu_dec u_alu_dec (
    .alu_class   (alu_class),
    .funct       (funct),
    .alu_control (alu_control)
  );

  // Strobes are gated by reset_n so a pending store drops in the same cycle reset is seen.
  assign pc_write   = reset_n & pc_write_s;
  assign ir_write   = reset_n & ir_write_s;
  assign mem_write  = reset_n & mem_write_s;
  assign reg_write  = reset_n & reg_write_s;
  assign halted     = reset_n & halted_s;
  assign illegal_op = reset_n & illegal_s;

endmodule

// File: tb/tb_mc_controller.sv
// Cycle-by-cycle vector bench for mc_controller: each row gives inputs and
// the expected state, from which the expected outputs are derived.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] op;
  logic [2:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control;
  logic       halted, illegal_op;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .result_src  (result_src),
    .halted      (halted),
    .illegal_op  (illegal_op)
  );

  typedef enum {
    T_RST, T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
    T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_JUMP, T_HALT
  } st_t;

  typedef struct {
    logic       rst_n;
    logic [3:0] op;
    logic [2:0] funct;
    logic       zero;
    logic       mr;
    st_t        st;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] exp;
    logic [15:0] mask;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  function automatic vec_t v(logic r, logic [3:0] o, logic [2:0] f, logic z, logic m, st_t s);
    vec_t t;
    t.rst_n = r; t.op = o; t.funct = f; t.zero = z; t.mr = m; t.st = s;
    return t;
  endfunction

  // Bit order: pcw irw adr mw rw a[2] b[2] alu[3] res[2] halted illegal
  function automatic logic [15:0] pk(logic pcw, logic irw, logic adr, logic mw, logic rw,
                                     logic [1:0] a, logic [1:0] b, logic [2:0] alu,
                                     logic [1:0] res, logic h, logic ill);
    return {pcw, irw, adr, mw, rw, a, b, alu, res, h, ill};
  endfunction

  function automatic logic [15:0] expect_out(vec_t t);
    case (t.st)
      T_RST:    return '0;
      T_FETCH:  return pk(t.mr, t.mr, 0, 0, 0, 2'b00, 2'b10, 3'b000, 2'b10, 0, 0);
      T_DECODE: return pk(0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 2'b00, 0, t.op > 4'd6);
      T_MEMADR: return pk(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0);
      T_MEMRD:  return pk(0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
      T_MEMWB:  return pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0);
      T_MEMWR:  return pk(0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
      T_EXECR:  return pk(0, 0, 0, 0, 0, 2'b10, 2'b00, t.funct, 2'b00, 0, 0);
      T_EXECI:  return pk(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0);
      T_ALUWB:  return pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
      T_BEQ:    return pk(t.zero, 0, 0, 0, 0, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0);
      T_JUMP:   return pk(1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0);
      T_HALT:   return pk(0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0);
      default:  return '0;
    endcase
  endfunction

  // During reset only the strobes, halted and illegal_op are defined.
  function automatic logic [15:0] expect_mask(vec_t t);
    if (t.st == T_RST) return pk(1, 1, 0, 1, 1, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1);
    return '1;
  endfunction

  task automatic check(string name, int unsigned idx, logic [7:0] act, logic [7:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %b, expected %b", idx, name, act, exp);
    end
  endtask

  initial begin
    sb_t  e;
    vec_t t;
    logic [15:0] act;

    // reset with mem_ready high: strobes stay low
    vecs.push_back(v(0, 4'h0, 3'd0, 0, 1, T_RST));
    vecs.push_back(v(0, 4'h0, 3'd0, 0, 1, T_RST));
    // R-type OR
    vecs.push_back(v(1, 4'h0, 3'b110, 0, 1, T_FETCH));
    vecs.push_back(v(1, 4'h0, 3'b110, 0, 1, T_DECODE));
    vecs.push_back(v(1, 4'h0, 3'b110, 0, 1, T_EXECR));
    vecs.push_back(v(1, 4'h0, 3'b110, 0, 1, T_ALUWB));
    // ADDI
    vecs.push_back(v(1, 4'h1, 3'b011, 0, 1, T_FETCH));
    vecs.push_back(v(1, 4'h1, 3'b011, 0, 1, T_DECODE));
    vecs.push_back(v(1, 4'h1, 3'b011, 0, 1, T_EXECI));
    vecs.push_back(v(1, 4'h1, 3'b011, 0, 1, T_ALUWB));
    // LW with 2 wait cycles in MEMRD
    vecs.push_back(v(1, 4'h2, 3'd0, 0, 1, T_FETCH));
    vecs.push_back(v(1, 4'h2, 3'd0, 0, 0, T_DECODE));
    vecs.push_back(v(1, 4'h2, 3'd0, 0, 0, T_MEMADR));
    vecs.push_back(v(1, 4'h2, 3'd0, 0, 0, T_MEMRD));
    vecs.push_back(v(1, 4'h2, 3'd0, 0, 0, T_MEMRD));
    vecs.push_back(v(1, 4'h2, 3'd0, 0, 1, T_MEMRD));
    vecs.push_back(v(1, 4'h2, 3'd0, 0, 0, T_MEMWB));
    // SW with mem_ready low 3 cycles
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 1, T_FETCH));
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 1, T_DECODE));
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 1, T_MEMADR));
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 0, T_MEMWR));
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 0, T_MEMWR));
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 0, T_MEMWR));
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 1, T_MEMWR));
    // BEQ taken, with one fetch wait
    vecs.push_back(v(1, 4'h4, 3'd0, 1, 0, T_FETCH));
    vecs.push_back(v(1, 4'h4, 3'd0, 1, 1, T_FETCH));
    vecs.push_back(v(1, 4'h4, 3'd0, 1, 1, T_DECODE));
    vecs.push_back(v(1, 4'h4, 3'd0, 1, 1, T_BEQ));
    // BEQ not taken; zero high outside BEQ must not matter
    vecs.push_back(v(1, 4'h4, 3'd0, 1, 1, T_FETCH));
    vecs.push_back(v(1, 4'h4, 3'd0, 1, 1, T_DECODE));
    vecs.push_back(v(1, 4'h4, 3'd0, 0, 1, T_BEQ));
    // JMP
    vecs.push_back(v(1, 4'h5, 3'd0, 0, 1, T_FETCH));
    vecs.push_back(v(1, 4'h5, 3'd0, 0, 1, T_DECODE));
    vecs.push_back(v(1, 4'h5, 3'd0, 0, 1, T_JUMP));
    // illegal opcodes
    vecs.push_back(v(1, 4'hA, 3'd0, 0, 1, T_FETCH));
    vecs.push_back(v(1, 4'hA, 3'd0, 0, 1, T_DECODE));
    vecs.push_back(v(1, 4'h7, 3'd0, 0, 1, T_FETCH));
    vecs.push_back(v(1, 4'h7, 3'd0, 0, 1, T_DECODE));
    // HALT is sticky until reset
    vecs.push_back(v(1, 4'h6, 3'd0, 0, 1, T_FETCH));
    vecs.push_back(v(1, 4'h6, 3'd0, 0, 1, T_DECODE));
    vecs.push_back(v(1, 4'h6, 3'd0, 0, 1, T_HALT));
    vecs.push_back(v(1, 4'h0, 3'd0, 1, 0, T_HALT));
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 1, T_HALT));
    vecs.push_back(v(1, 4'hA, 3'd0, 1, 0, T_HALT));
    vecs.push_back(v(0, 4'h0, 3'd0, 0, 1, T_RST));
    vecs.push_back(v(1, 4'h0, 3'd0, 0, 0, T_FETCH));
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 1, T_FETCH));
    // reset while MEMWR is waiting
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 1, T_DECODE));
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 1, T_MEMADR));
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 0, T_MEMWR));
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 0, T_MEMWR));
    vecs.push_back(v(0, 4'h3, 3'd0, 0, 0, T_RST));
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 0, T_FETCH));
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 0, T_FETCH));
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 1, T_FETCH));
    vecs.push_back(v(1, 4'h3, 3'd0, 0, 1, T_DECODE));

    reset_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      t = vecs[i];
      reset_n = t.rst_n; op = t.op; funct = t.funct; zero = t.zero; mem_ready = t.mr;
      e.idx  = i;
      e.exp  = expect_out(t);
      e.mask = expect_mask(t);
      sb.push_back(e);

      @(negedge clk);
      e = sb.pop_front();
      act = {pc_write, ir_write, adr_src, mem_write, reg_write, alu_src_a, alu_src_b,
             alu_control, result_src, halted, illegal_op};
      n_vec++;
      if ((act & e.mask) !== (e.exp & e.mask)) begin
        n_fail++;
        $display("FAIL vec%0d: outputs %b, expected %b (mask %b)", e.idx, act, e.exp, e.mask);
      end

      if (t.st == T_RST)
        check("reset strobes", i,
              {2'b00, pc_write, ir_write, mem_write, reg_write, halted, illegal_op}, '0);

      if ((t.st == T_MEMWR || t.st == T_MEMRD) && t.mr)
        check("expired wait adr/mem_write", i,
              {6'b000000, adr_src, mem_write},
              {6'b000000, 1'b1, (t.st == T_MEMWR)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
